ed25519_point_compress: RTL and testbench
=========================================

Name: ed25519_point_compress

Overview:
- Downstream stage of the ed25519 scalar-multiply core.
- Consumes the core's 8-word affine result stream (xg then yg, each 4×64-bit words, MSB word first) over a valid/ready handshake.
- Emits the 256-bit compressed point encoding as 4×64-bit words: bit 255 = parity of xg (xg[0]), bits 254:0 = yg.
- Flags non-canonical yg (yg ≥ Q) and malformed top words.

Parameters:
- DATA_W, 64, stream word width; only 64 is supported.
- CHECK_CANON, 1, 1 = compute o_err from the canonicality checks; 0 = o_err tied 0.

Ports:
- i_clk  input  1  clock
- i_rst  input  1  reset; synchronous, active-high; clock i_clk
- i_in_valid  input  1  upstream word valid (from core o_out_valid)
- o_in_ready  output  1  block accepts a word this cycle (to core i_out_ready)
- i_in_data  input  64  upstream word: x w0..w3, then y w0..w3; w0 holds bits 254:192 in [62:0]
- o_out_valid  output  1  encoded word valid
- i_out_ready  input  1  downstream accepts word
- o_out_data  output  64  encoded word
- o_out_last  output  1  high with the 4th encoded word
- o_err  output  1  sideband, valid with every output word of the point

Behaviour:
- Reset values: o_in_ready=0, o_out_valid=0, o_out_data=0, o_out_last=0, o_err=0; FSM to RX_X; word index 0; y buffer and flags cleared.
- Handshakes:
  - A transfer occurs on valid&ready at a clock edge.
  - o_out_data, o_out_last and o_err stay stable while o_out_valid=1 and i_out_ready=0.
  - o_out_valid never drops without a handshake.
- FSM: RX_X → RX_Y → TX → RX_X.
  - RX_X: o_in_ready=1. Count 4 handshakes with a 2-bit index.
    - On index 0: err_top = i_in_data[63].
    - On index 3: xpar = i_in_data[0].
    - After the 4th handshake, go to RX_Y with index 0.
  - RX_Y: o_in_ready=1. Store words into ybuf[255:0] at index positions (MSB first).
    - On index 0: err_top |= i_in_data[63].
    - After the 4th handshake, go to TX; the canonical compare is registered in the same edge.
  - TX: o_in_ready=0, o_out_valid=1. Emit 4 words; index advances on output handshake.
    - After the 4th handshake, go to RX_X, clear err_top and xpar.
- Encoded word order (default): w0 = {xpar, ybuf[254:192]}, w1 = ybuf[191:128], w2 = ybuf[127:64], w3 = ybuf[63:0]; o_out_last on w3.
- Latency: first encoded word has o_out_valid=1 the cycle after the last y handshake. Peak throughput is 12 cycles per point.
- Canonical check (when CHECK_CANON=1):
  - y_ge_q = (ybuf[254:5] all ones) && (ybuf[4:0] ≥ 5'd13), i.e. yg ≥ 2^255−19.
  - o_err = y_ge_q | err_top.
  - The output encoding is still emitted unchanged.
- Input data is ignored while o_in_ready=0.
- Upstream valid arriving during TX is back-pressured and not lost.
- i_rst asserted mid-point: state, indices and partial buffers are discarded next edge; outputs return to reset values; no partial encoding is emitted after reset.
- Simultaneous input and output handshakes cannot occur, since ready and valid are state-exclusive.

Optional Feature:
- Macro PC_LE_OUT_EN.
- Defined: RFC 8032 little-endian byte order.
  - Words are emitted LSB word first: bswap(w3), bswap(w2), bswap(w1), bswap(w0).
  - bswap reverses the 8 bytes of a word; w0 is still {xpar, ybuf[254:192]}.
  - o_out_last is on bswap(w0).
- Undefined: big-endian MSB-word-first order as above; no byte-swap logic is synthesized.

Decomposition:
- Shared package ed25519_pkg:
  - Q constant (255-bit).
  - Word-index typedef (2-bit).
  - FSM state enum {RX_X, RX_Y, TX}.
  - Q_LOW5 = 5'd13 constant.
- One natural sub-module: ed25519_canon_check.
  - Combinational y ≥ Q comparator on 255 bits.
  - Reusable by a future input-side validator for xp/yp.

Test Plan:
- x = 1 (words 0,0,0,0x1), y = 2 (0,0,0,0x2), i_out_ready=1 → out 0x8000000000000000, 0, 0, 0x2; o_out_last on 4th; o_err=0; first out valid 1 cycle after 8th input handshake.
- y = Q−1 (0x7FFFFFFFFFFFFFFF, 0xFFFFFFFFFFFFFFFF ×2, 0xFFFFFFFFFFFFFFEC), x even → o_err=0, w0 = 0x7FFFFFFFFFFFFFFF; repeat with low word 0xFFFFFFFFFFFFFFED (y = Q) → o_err=1 on all 4 words.
- i_out_ready held 0 for 5 cycles at w1 with random input valid toggling → o_out_data frozen at w1, o_in_ready=0, no input consumed; release → w2, w3 follow.
- i_in_data[63]=1 on y w0 → o_err=1 for that point; the next clean point → o_err=0.
- i_rst pulsed after 6 input words → outputs 0, o_in_ready=1 next cycle; fresh 8-word point encodes correctly.
- PC_LE_OUT_EN defined, x = 1, y = 2 → out 0x0200000000000000, 0, 0, 0x0000000000000080 with o_out_last on last.

Source files
------------

// File: rtl/ed25519_pkg.sv
// Shared ed25519 constants and types: field prime Q, word index, stream FSM states.
package ed25519_pkg;

  // Field prime Q = 2^255 - 19: 250 ones above a low 5-bit field of 13.
  localparam logic [254:0] Q      = {{250{1'b1}}, 5'd13};
  localparam logic [4:0]   Q_LOW5 = 5'd13;

  typedef logic [1:0] widx_t;

  typedef enum logic [1:0] {RX_X, RX_Y, TX} state_t;

  // Reverse the 8 bytes of a 64-bit word.
  function automatic logic [63:0] bswap64(input logic [63:0] w);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = w[56-8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/ed25519_point_compress_if.sv
// Stream bundle between the scalar-multiply core, the compressor and its consumer.
// master = environment side, slave = compressor side.
interface ed25519_point_compress_if #(parameter int DATA_W = 64);
  logic              i_in_valid;
  logic              o_in_ready;
  logic [DATA_W-1:0] i_in_data;
  logic              o_out_valid;
  logic              i_out_ready;
  logic [DATA_W-1:0] o_out_data;
  logic              o_out_last;
  logic              o_err;

  modport master (
    output i_in_valid, i_in_data, i_out_ready,
    input  o_in_ready, o_out_valid, o_out_data, o_out_last, o_err
  );

  modport slave (
    input  i_in_valid, i_in_data, i_out_ready,
    output o_in_ready, o_out_valid, o_out_data, o_out_last, o_err
  );
endinterface

// File: rtl/ed25519_canon_check.sv
// Combinational y >= Q test on a 255-bit field element.
// Q has all ones above bit 5, so only the low 5 bits need a magnitude compare.
module ed25519_canon_check
  import ed25519_pkg::*;
(
  input  logic [254:0] y,
  output logic         y_ge_q
);

  assign y_ge_q = (y[254:5] == Q[254:5]) && (y[4:0] >= Q_LOW5);

endmodule

// File: rtl/ed25519_point_compress.sv
// ed25519 point compressor: takes xg,yg (4x64 words each, MSB word first) and
// emits the 256-bit encoding {parity(xg), yg[254:0]} as 4 words, flagging
// non-canonical yg and set top bits on o_err.
// Optional macro PC_LE_OUT_EN: emit RFC 8032 little-endian byte order
// (LSB word first, each word byte-swapped).
module ed25519_point_compress
  import ed25519_pkg::*;
#(
  parameter int DATA_W      = 64,
  parameter bit CHECK_CANON = 1'b1
)(
  input  logic i_clk,
  input  logic i_rst,
  ed25519_point_compress_if.slave bus
);

  state_t            state, state_nxt;
  widx_t             idx, sel;
  logic [254:0]      ybuf;
  logic              err_top, xpar, y_ge_q, ge_now;
  logic              in_hs, out_hs, idx_last;
  logic [DATA_W-1:0] word_be;

  assign in_hs    = bus.i_in_valid & bus.o_in_ready;
  assign out_hs   = bus.o_out_valid & bus.i_out_ready;
  assign idx_last = (idx == 2'd3);

  // Compare the buffer as it will look once the incoming low y word lands,
  // so the flag is registered on the same edge as the last y word.
  ed25519_canon_check u_canon (
    .y      ({ybuf[254:64], bus.i_in_data}),
    .y_ge_q (ge_now)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= RX_X;
    else       state <= state_nxt;
  end

  // Next state: four words per phase.
  always_comb begin
    state_nxt = state;
    case (state)
      RX_X:    if (in_hs && idx_last)  state_nxt = RX_Y;
      RX_Y:    if (in_hs && idx_last)  state_nxt = TX;
      TX:      if (out_hs && idx_last) state_nxt = RX_X;
      default: state_nxt = RX_X;
    endcase
  end

  // Word index, y buffer and sideband flags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      idx     <= '0;
      ybuf    <= '0;
      err_top <= 1'b0;
      xpar    <= 1'b0;
      y_ge_q  <= 1'b0;
    end else begin
      case (state)
        RX_X: if (in_hs) begin
          if (idx == 2'd0) err_top <= bus.i_in_data[63];
          if (idx_last)    xpar    <= bus.i_in_data[0];
          idx <= idx + 2'd1;
        end
        RX_Y: if (in_hs) begin
          case (idx)
            2'd0: begin
              ybuf[254:192] <= bus.i_in_data[62:0];
              err_top       <= err_top | bus.i_in_data[63];
            end
            2'd1:    ybuf[191:128] <= bus.i_in_data;
            2'd2:    ybuf[127:64]  <= bus.i_in_data;
            default: begin
              ybuf[63:0] <= bus.i_in_data;
              y_ge_q     <= ge_now;
            end
          endcase
          idx <= idx + 2'd1;
        end
        TX: if (out_hs) begin
          if (idx_last) begin
            err_top <= 1'b0;
            xpar    <= 1'b0;
          end
          idx <= idx + 2'd1;
        end
        default: idx <= '0;
      endcase
    end
  end

  // Pick which big-endian encoded word goes out for this output slot.
`ifdef PC_LE_OUT_EN
  assign sel = ~idx;
`else
  assign sel = idx;
`endif

  // Big-endian encoded word for the selected slot.
  always_comb begin
    case (sel)
      2'd0:    word_be = {xpar, ybuf[254:192]};
      2'd1:    word_be = ybuf[191:128];
      2'd2:    word_be = ybuf[127:64];
      default: word_be = ybuf[63:0];
    endcase
  end

  // Outputs decoded from state; everything forced to idle while in reset.
  always_comb begin
    bus.o_in_ready  = 1'b0;
    bus.o_out_valid = 1'b0;
    bus.o_out_data  = '0;
    bus.o_out_last  = 1'b0;
    bus.o_err       = 1'b0;
    if (!i_rst) begin
      case (state)
        RX_X, RX_Y: bus.o_in_ready = 1'b1;
        TX: begin
          bus.o_out_valid = 1'b1;
`ifdef PC_LE_OUT_EN
          bus.o_out_data  = bswap64(word_be);
`else
          bus.o_out_data  = word_be;
`endif
          bus.o_out_last  = idx_last;
          bus.o_err       = CHECK_CANON ? (y_ge_q | err_top) : 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ed25519_point_compress.sv
// Self-checking bench for ed25519_point_compress: directed cases plus random
// points compared against a byte-level model of the point encoding.
module tb_ed25519_point_compress;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ed25519_point_compress_if #(.DATA_W(64)) bus();

  ed25519_point_compress #(.DATA_W(64), .CHECK_CANON(1'b1)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // Reference: build the 256-bit value, then cut it into output words.
  function automatic void model(input logic [3:0][63:0] xw, input logic [3:0][63:0] yw,
                                output logic [3:0][63:0] ow, output logic err);
    logic [255:0] xv, yv, enc, q;
    logic [7:0]   b [32];
    xv  = {xw[0], xw[1], xw[2], xw[3]};
    yv  = {yw[0], yw[1], yw[2], yw[3]};
    q   = (256'd1 << 255) - 256'd19;
    err = xv[255] | yv[255] | ({1'b0, yv[254:0]} >= q);
    enc = {xv[0], yv[254:0]};
`ifdef PC_LE_OUT_EN
    for (int k = 0; k < 32; k++) b[k] = enc[8*k +: 8];
    for (int j = 0; j < 4; j++)
      for (int m = 0; m < 8; m++) ow[j][63-8*m -: 8] = b[8*j+m];
`else
    for (int k = 0; k < 32; k++) b[k] = 8'h0;
    for (int j = 0; j < 4; j++) ow[j] = enc[255-64*j -: 64];
`endif
  endfunction

  task automatic send_word(input logic [63:0] d, input int gap, output bit to);
    int n;
    n = 0; to = 1'b0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    bus.i_in_valid = 1'b1;
    bus.i_in_data  = d;
    while (!bus.o_in_ready) begin
      @(negedge clk);
      n++;
      if (n > 40) begin to = 1'b1; break; end
    end
    @(posedge clk); #1;
    bus.i_in_valid = 1'b0;
    bus.i_in_data  = {$urandom, $urandom};
  endtask

  task automatic send_point(input logic [3:0][63:0] xw, input logic [3:0][63:0] yw,
                            input int max_gap, output bit to);
    bit t;
    to = 1'b0;
    for (int i = 0; i < 4; i++) begin send_word(xw[i], $urandom_range(0, max_gap), t); to |= t; end
    for (int i = 0; i < 4; i++) begin send_word(yw[i], $urandom_range(0, max_gap), t); to |= t; end
  endtask

  // Called at posedge+1; returns after the output handshake edge (+1).
  task automatic recv_word(input int stall_max, output logic [63:0] d, output logic l,
                           output logic e, output int waited, output bit to);
    waited = 0; to = 1'b0; d = '0; l = 1'b0; e = 1'b0;
    forever begin
      bus.i_out_ready = (stall_max == 0) || ($urandom_range(0, stall_max) == 0);
      if (bus.o_out_valid && bus.i_out_ready) begin
        d = bus.o_out_data; l = bus.o_out_last; e = bus.o_err;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      waited++;
      if (waited > 60) begin to = 1'b1; break; end
    end
    bus.i_out_ready = 1'b1;
  endtask

  task automatic recv_point(input int stall_max, output logic [3:0][63:0] d,
                            output logic [3:0] l, output logic [3:0] e,
                            output int first_wait, output bit to);
    int w; bit t;
    to = 1'b0; first_wait = 0;
    for (int j = 0; j < 4; j++) begin
      recv_word(stall_max, d[j], l[j], e[j], w, t);
      to |= t;
      if (j == 0) first_wait = w;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk); #1;
    n_chk++;
    if ({bus.o_in_ready, bus.o_out_valid, bus.o_out_last, bus.o_err} !== 4'b0000 || bus.o_out_data !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy=%b vld=%b last=%b err=%b data=%h required all 0",
               bus.o_in_ready, bus.o_out_valid, bus.o_out_last, bus.o_err, bus.o_out_data);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if (bus.o_in_ready !== 1'b1 || bus.o_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: rdy=%b vld=%b required 1 0", bus.o_in_ready, bus.o_out_valid);
    end
  endtask

  task automatic test_basic();
    logic [3:0][63:0] xw, yw, got, req;
    logic [3:0] l, e;
    int fw; bit t1, t2;
    xw = '0; xw[3] = 64'd1;
    yw = '0; yw[3] = 64'd2;
`ifdef PC_LE_OUT_EN
    req = '0; req[0] = 64'h0200000000000000; req[3] = 64'h0000000000000080;
`else
    req = '0; req[0] = 64'h8000000000000000; req[3] = 64'h0000000000000002;
`endif
    send_point(xw, yw, 0, t1);
    recv_point(0, got, l, e, fw, t2);
    n_chk++;
    if (t1 || t2) begin n_fail++; $display("FAIL basic_timeout: in=%b out=%b required 0 0", t1, t2); end
    for (int j = 0; j < 4; j++) begin
      n_chk++;
      if (got[j] !== req[j]) begin
        n_fail++; $display("FAIL basic_w%0d: got %h required %h", j, got[j], req[j]);
      end
    end
    n_chk++;
    if (l !== 4'b1000 || e !== 4'b0000) begin
      n_fail++; $display("FAIL basic_side: last=%b err=%b required 1000 0000", l, e);
    end
    n_chk++;
    if (fw !== 0) begin n_fail++; $display("FAIL basic_latency: waited %0d cycles required 0", fw); end
  endtask

  task automatic test_canon();
    logic [3:0][63:0] xw, yw, got, req;
    logic [3:0] l, e;
    logic merr;
    int fw; bit t1, t2;
    for (int pass = 0; pass < 2; pass++) begin
      xw = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      xw[0][63] = 1'b0;
      xw[3][0]  = 1'b0;
      yw[0] = 64'h7FFFFFFFFFFFFFFF;
      yw[1] = 64'hFFFFFFFFFFFFFFFF;
      yw[2] = 64'hFFFFFFFFFFFFFFFF;
      yw[3] = (pass == 0) ? 64'hFFFFFFFFFFFFFFEC : 64'hFFFFFFFFFFFFFFED;
      model(xw, yw, req, merr);
      send_point(xw, yw, 1, t1);
      recv_point(0, got, l, e, fw, t2);
      n_chk++;
      if (t1 || t2 || got !== req) begin
        n_fail++; $display("FAIL canon%0d_words: got %h required %h (to %b%b)", pass, got, req, t1, t2);
      end
      n_chk++;
      if (e !== ((pass == 0) ? 4'b0000 : 4'b1111)) begin
        n_fail++; $display("FAIL canon%0d_err: got %b required %b", pass, e, (pass == 0) ? 4'b0000 : 4'b1111);
      end
`ifndef PC_LE_OUT_EN
      n_chk++;
      if (got[0] !== 64'h7FFFFFFFFFFFFFFF) begin
        n_fail++; $display("FAIL canon%0d_w0: got %h required 7fffffffffffffff", pass, got[0]);
      end
`endif
    end
  endtask

  task automatic test_backpressure();
    logic [3:0][63:0] xw, yw, got, req;
    logic [3:0] l, e;
    logic merr;
    int w; bit t1, t2, t3;
    xw = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    yw = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    xw[0][63] = 1'b0; yw[0][63] = 1'b0;
    model(xw, yw, req, merr);
    send_point(xw, yw, 0, t1);
    recv_word(0, got[0], l[0], e[0], w, t2);
    bus.i_out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      bus.i_in_valid = $urandom_range(0, 1);
      bus.i_in_data  = {$urandom, $urandom};
      @(posedge clk); #1;
      n_chk++;
      if (bus.o_out_valid !== 1'b1 || bus.o_in_ready !== 1'b0 || bus.o_out_data !== req[1]) begin
        n_fail++;
        $display("FAIL stall_c%0d: vld=%b rdy=%b data=%h required 1 0 %h",
                 c, bus.o_out_valid, bus.o_in_ready, bus.o_out_data, req[1]);
      end
    end
    bus.i_in_valid = 1'b0;
    for (int j = 1; j < 4; j++) begin recv_word(0, got[j], l[j], e[j], w, t3); t2 |= t3; end
    n_chk++;
    if (t1 || t2 || got !== req || l !== 4'b1000) begin
      n_fail++; $display("FAIL stall_words: got %h last %b required %h 1000", got, l, req);
    end
    // A following point proves no stray input word was swallowed during the stall.
    xw = '0; xw[3] = 64'd3; yw = '0; yw[3] = 64'h55;
    model(xw, yw, req, merr);
    send_point(xw, yw, 0, t1);
    recv_point(0, got, l, e, w, t2);
    n_chk++;
    if (t1 || t2 || got !== req || e !== {4{merr}}) begin
      n_fail++; $display("FAIL stall_next: got %h err %b required %h %b", got, e, req, {4{merr}});
    end
  endtask

  task automatic test_err_top();
    logic [3:0][63:0] xw, yw, got, req;
    logic [3:0] l, e;
    logic merr;
    int fw; bit t1, t2;
    for (int pass = 0; pass < 2; pass++) begin
      xw = '0; xw[3] = 64'd7;
      yw = '0; yw[3] = 64'd9;
      if (pass == 0) yw[0] = 64'h8000000000000001;
      model(xw, yw, req, merr);
      send_point(xw, yw, 0, t1);
      recv_point(0, got, l, e, fw, t2);
      n_chk++;
      if (t1 || t2 || got !== req) begin
        n_fail++; $display("FAIL errtop%0d_words: got %h required %h", pass, got, req);
      end
      n_chk++;
      if (e !== ((pass == 0) ? 4'b1111 : 4'b0000)) begin
        n_fail++; $display("FAIL errtop%0d_err: got %b required %b", pass, e, (pass == 0) ? 4'b1111 : 4'b0000);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [3:0][63:0] xw, yw, got, req;
    logic [3:0] l, e;
    logic merr;
    int fw; bit t1, t2;
    for (int i = 0; i < 6; i++) send_word({$urandom, $urandom}, 0, t1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if ({bus.o_in_ready, bus.o_out_valid, bus.o_out_last, bus.o_err} !== 4'b0000 || bus.o_out_data !== 64'h0) begin
      n_fail++; $display("FAIL midrst_outputs: rdy=%b vld=%b data=%h required 0 0 0",
                         bus.o_in_ready, bus.o_out_valid, bus.o_out_data);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if (bus.o_in_ready !== 1'b1 || bus.o_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL midrst_release: rdy=%b vld=%b required 1 0", bus.o_in_ready, bus.o_out_valid);
    end
    xw = '0; xw[3] = 64'd1; yw = '0; yw[2] = 64'hABCD; yw[3] = 64'h1234;
    model(xw, yw, req, merr);
    send_point(xw, yw, 0, t1);
    recv_point(0, got, l, e, fw, t2);
    n_chk++;
    if (t1 || t2 || got !== req || l !== 4'b1000 || e !== 4'b0000) begin
      n_fail++; $display("FAIL midrst_point: got %h last %b err %b required %h 1000 0000", got, l, e, req);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0][63:0] xw, yw, got, req;
    logic [3:0] l, e;
    logic merr;
    int fw, c0; bit t1, t2;
    for (int p = 0; p < 3; p++) begin
      xw = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      yw = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      model(xw, yw, req, merr);
      c0 = cyc;
      send_point(xw, yw, 0, t1);
      recv_point(0, got, l, e, fw, t2);
      n_chk++;
      if (t1 || t2 || got !== req || e !== {4{merr}} || (cyc - c0) !== 12) begin
        n_fail++; $display("FAIL b2b%0d: got %h err %b cycles %0d required %h %b 12",
                           p, got, e, cyc - c0, req, {4{merr}});
      end
    end
  endtask

  task automatic test_random();
    logic [3:0][63:0] xw, yw, got, req;
    logic [3:0] l, e;
    logic merr;
    int fw; bit t1, t2;
    for (int p = 0; p < 25; p++) begin
      xw = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      yw = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 7) != 0) xw[0][63] = 1'b0;
      if ($urandom_range(0, 7) != 0) yw[0][63] = 1'b0;
      if ($urandom_range(0, 2) == 0) begin
        yw[0][62:0] = {63{1'b1}};
        yw[1] = '1;
        yw[2] = '1;
        yw[3] = {59'h7FFFFFFFFFFFFFF, 5'($urandom_range(0, 31))};
      end
      model(xw, yw, req, merr);
      send_point(xw, yw, 2, t1);
      recv_point(2, got, l, e, fw, t2);
      n_chk++;
      if (t1 || t2 || got !== req || l !== 4'b1000 || e !== {4{merr}}) begin
        n_fail++; $display("FAIL rand%0d: got %h last %b err %b required %h 1000 %b",
                           p, got, l, e, req, {4{merr}});
      end
    end
  endtask

  initial begin
    bus.i_in_valid  = 1'b0;
    bus.i_in_data   = '0;
    bus.i_out_ready = 1'b1;
    test_reset();
    test_basic();
    test_canon();
    test_backpressure();
    test_err_top();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
